// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor with a start/busy/done handshake.
// DIGIT bits are summed per cycle and the carry between digits is kept in a register.
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o,
    output logic             negative_o
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;

    int               base_s;
    logic [DIGIT-1:0] a_dig_s;
    logic [DIGIT-1:0] b_dig_s;
    logic [DIGIT:0]   dig_sum_s;
    logic [WIDTH-1:0] sum_d;

    // Current digit sum, merged into the partial result so the final edge sees the full sum
    always_comb begin
        base_s    = int'(cnt_q) * DIGIT;
        a_dig_s   = a_q[base_s +: DIGIT];
        b_dig_s   = b_q[base_s +: DIGIT];
        dig_sum_s = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, carry_q};
        sum_d     = sum_q;
        sum_d[base_s +: DIGIT] = dig_sum_s[DIGIT-1:0];
    end

    // Sequencer, datapath registers and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CW{1'b0}};
            carry_q    <= 1'b0;
            a_q        <= {WIDTH{1'b0}};
            b_q        <= {WIDTH{1'b0}};
            sum_q      <= {WIDTH{1'b0}};
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= {WIDTH{1'b0}};
            carry_o    <= 1'b0;
            overflow_o <= 1'b0;
            zero_o     <= 1'b0;
            negative_o <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        // Subtraction is a + ~b + 1; the +1 enters as the initial carry
                        a_q     <= a_i;
                        b_q     <= op_i ? ~b_i : b_i;
                        cnt_q   <= {CW{1'b0}};
                        carry_q <= op_i;
                        sum_q   <= {WIDTH{1'b0}};
                        busy_o  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        busy_o  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= dig_sum_s[DIGIT];
                    if (cnt_q == CNT_LAST) begin
                        state_q    <= S_DONE;
                        done_o     <= 1'b1;
                        result_o   <= sum_d;
                        carry_o    <= dig_sum_s[DIGIT];
                        overflow_o <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                      (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                        zero_o     <= (sum_d == {WIDTH{1'b0}});
                        negative_o <= sum_d[WIDTH-1];
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DONE: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule
